// File: rtl/uart_rx_deframer.sv
// UART receive deframer.
// Oversamples the synchronised serial line, takes a 2-of-3 majority vote near
// each bit centre, checks optional parity and the stop bit, and hands each
// received word to the RX FIFO as a single-cycle write with status flags.
module uart_rx_deframer #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 PCLK,
  input  logic                 PRSTn,
  input  logic                 rx_en,
  input  logic                 Rx_s,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [7:0]           prescale,
  input  logic                 par_en,
  input  logic                 par_type,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 rx_busy
);

  localparam int BIT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic                 sync1, sync2, sync_prev;
  logic [1:0]           flush;
  logic                 armed;
  logic                 start_det;
  logic [DIV_W-1:0]     div_eff, div_cnt;
  logic [7:0]           presc_eff, tick_cnt;
  logic [8:0]           cnt_next, mid;
  logic                 tick, bit_end, at_s0, at_s1, at_vote;
  logic                 samp0, samp1, vote;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 par_err;
  logic                 deliver;

  // Two-flop synchroniser plus edge-history flop; 'armed' waits until the
  // pipeline holds real line data that has been seen high after reset.
  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    if (!PRSTn) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      flush     <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync1     <= Rx_s;
      sync2     <= sync1;
      sync_prev <= sync2;
      flush     <= {flush[0], 1'b1};
      armed     <= armed | (flush[1] & sync2);
    end
  end

  assign start_det = armed & sync_prev & ~sync2;

  // Divisor and prescale clamps, tick strobe and sample positions. Samples
  // land on the ticks that advance tick_cnt to mid-1, mid and mid+1, which
  // centres the middle sample on the bit.
  assign div_eff   = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign presc_eff = (prescale < 8'd4) ? 8'd4 : prescale;
  assign tick      = (div_cnt == div_eff - DIV_W'(1));
  assign cnt_next  = {1'b0, tick_cnt} + 9'd1;
  assign mid       = {2'b00, presc_eff[7:1]};
  assign bit_end   = tick && (tick_cnt == presc_eff - 8'd1);
  assign at_s0     = tick && (cnt_next == mid - 9'd1);
  assign at_s1     = tick && (cnt_next == mid);
  assign at_vote   = tick && (cnt_next == mid + 9'd1);
  assign vote      = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);
  assign rx_busy   = (state != IDLE);

  // Baud divider and bit-phase counter; held clear while idle so a detected
  // start edge always begins from zero phase.
  always_ff @(posedge PCLK) begin
    if (!PRSTn || state == IDLE) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      tick_cnt <= bit_end ? 8'd0 : tick_cnt + 8'd1;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Capture the first two majority samples of the current bit.
  always_ff @(posedge PCLK) begin
    if (!PRSTn) begin
      samp0 <= 1'b1;
      samp1 <= 1'b1;
    end else begin
      if (at_s0) samp0 <= sync2;
      if (at_s1) samp1 <= sync2;
    end
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (!PRSTn) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and delivery strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_next = state;
    deliver    = 1'b0;
    if (state != IDLE && !rx_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:   if (rx_en && start_det) state_next = START;
        START:  if (at_vote && vote)    state_next = IDLE;
                else if (bit_end)       state_next = DATA;
        DATA:   if (bit_end && bit_cnt == BIT_W'(DATA_BITS))
                  state_next = par_en ? PARITY : STOP;
        PARITY: if (bit_end)            state_next = STOP;
        STOP:   if (at_vote) begin
                  deliver    = 1'b1;
                  state_next = IDLE;
                end
        default: state_next = IDLE;
      endcase
    end
  end

  // Data shift register, bit counter and parity check.
  always_ff @(posedge PCLK) begin
    if (!PRSTn) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_err   <= 1'b0;
    end else if (state == IDLE && start_det) begin
      bit_cnt   <= '0;
      par_err   <= 1'b0;
    end else if (state == DATA && at_vote) begin
      shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
      bit_cnt   <= bit_cnt + BIT_W'(1);
    end else if (state == PARITY && at_vote) begin
      par_err   <= (^shift_reg) ^ vote ^ par_type;
    end
  end

  // FIFO write port: one-cycle strobe with flags, data held between writes.
  always_ff @(posedge PCLK) begin
    if (!PRSTn) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_valid     <= deliver;
      parity_error <= deliver & par_en & par_err;
      frame_error  <= deliver & ~vote;
      if (deliver) rx_data <= shift_reg;
    end
  end

endmodule
